series_datapath: RTL and testbench

- Arithmetic datapath driven cycle-by-cycle by the series-evaluation controller.
- Evaluates the truncated alternating series r = sum_{k=1..N_TERMS} (-1)^(k+1) * x^k / k!, i.e. 1 - e^(-x), for unsigned fractional x.
- Owns the x, term and result registers, the iteration counter and the 1/k coefficient ROM.
- Returns y_bigger to the controller; presents the result to the downstream consumer.

---
 rtl/series_pkg.sv | 22 ++
 rtl/series_coef_rom.sv | 20 ++
 rtl/series_datapath.sv | 93 +++++++++
 tb/tb_series_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// Shared widths, constants and the 1/k coefficient function for the series datapaths.
// Optional round-half-up multiplier behaviour is selected with SERIES_ROUND_EN in series_datapath.
package series_pkg;

  localparam int FRAC_W  = 16;
  localparam int N_TERMS = 8;
  localparam int CNT_W   = 4;
  localparam int T_W     = FRAC_W + 1;
  localparam int R_W     = FRAC_W + 3;
  localparam int P_W     = 2 * T_W;

  localparam logic [T_W-1:0] ONE = T_W'(1) << FRAC_W;

  // round(2^frac_w / k) for k in 1..n_terms; every other index reads 0
  function automatic int recip(input int k, input int n_terms, input int frac_w);
    if (k < 1 || k > n_terms) begin
      return 0;
    end
    return ((1 << frac_w) + k / 2) / k;
  endfunction

endpackage

// File: rtl/series_coef_rom.sv
// Combinational 1/k lookup indexed by the iteration counter, Q1.16 entries.
// Shared by the series-evaluation datapaths.
module series_coef_rom
  import series_pkg::*;
(
  input  logic [CNT_W-1:0] i_cnt,
  output logic [T_W-1:0]   o_coef
);

  localparam int DEPTH = 1 << CNT_W;

  logic [T_W-1:0] w_table [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
    assign w_table[gi] = T_W'(recip(gi, N_TERMS, FRAC_W));
  end

  assign o_coef = w_table[i_cnt];

endmodule

// File: rtl/series_datapath.sv
// Datapath for r = sum (-1)^(k+1) x^k/k! (1 - e^-x), sequenced externally by the controller.
// Define SERIES_ROUND_EN to round the multiplier result half-up instead of truncating.
module series_datapath
  import series_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FRAC_W-1:0] x_in,
  input  logic              x_ld,
  input  logic              t_init,
  input  logic              t_ld,
  input  logic              sel,
  input  logic              r_init,
  input  logic              r_ld,
  input  logic              as_sel,
  input  logic              cnt_iz,
  input  logic              cnt_en,
  output logic              y_bigger,
  output logic [R_W-1:0]    r_out,
  output logic [T_W-1:0]    t_out
);

`ifdef SERIES_ROUND_EN
  localparam logic [P_W-1:0] RND = P_W'(1) << (FRAC_W - 1);
`else
  localparam logic [P_W-1:0] RND = '0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(N_TERMS);

  logic [FRAC_W-1:0] r_x;
  logic [T_W-1:0]    r_t;
  logic [R_W-1:0]    r_r;
  logic [CNT_W-1:0]  r_cnt;

  logic [T_W-1:0]    w_coef;
  logic [T_W-1:0]    w_op;
  logic [T_W-1:0]    w_mult;
  logic [R_W-1:0]    w_t_ext;
  logic [R_W-1:0]    w_sum;

  series_coef_rom u_coef_rom (
    .i_cnt  (r_cnt),
    .o_coef (w_coef)
  );

  assign w_op = sel ? w_coef : {1'b0, r_x};

  // Both operands are <= 1.0, so the Q1.16 slice of the product never overflows
  assign w_mult = T_W'(({{T_W{1'b0}}, r_t} * {{T_W{1'b0}}, w_op} + RND) >> FRAC_W);

  assign w_t_ext = {{(R_W - T_W){1'b0}}, r_t};
  assign w_sum   = as_sel ? (r_r + w_t_ext) : (r_r - w_t_ext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x   <= '0;
      r_t   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else begin
      if (x_ld) begin
        r_x <= x_in;
      end

      if (t_init) begin
        r_t <= ONE;
      end else if (t_ld) begin
        r_t <= w_mult;
      end

      if (r_init) begin
        r_r <= '0;
      end else if (r_ld) begin
        r_r <= w_sum;
      end

      // Counter saturates at all-ones rather than wrapping back into the ROM range
      if (cnt_iz) begin
        r_cnt <= CNT_ONE;
      end else if (cnt_en && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign y_bigger = (r_cnt >= CNT_END);
  assign r_out    = r_r;
  assign t_out    = r_t;

endmodule

// File: tb/tb_series_datapath.sv
// Directed bench for series_datapath: a behavioural model pushes expected state to a
// scoreboard queue on each driven cycle; entries are popped and checked after the edge.
module tb_series_datapath;

  logic        clk;
  logic        rst;
  logic [15:0] x_in;
  logic        x_ld, t_init, t_ld, sel, r_init, r_ld, as_sel, cnt_iz, cnt_en;
  logic        y_bigger;
  logic [18:0] r_out;
  logic [16:0] t_out;

  series_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .x_ld     (x_ld),
    .t_init   (t_init),
    .t_ld     (t_ld),
    .sel      (sel),
    .r_init   (r_init),
    .r_ld     (r_ld),
    .as_sel   (as_sel),
    .cnt_iz   (cnt_iz),
    .cnt_en   (cnt_en),
    .y_bigger (y_bigger),
    .r_out    (r_out),
    .t_out    (t_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] t;
    logic [18:0] r;
    logic        yb;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_x;
  logic [16:0] m_t;
  logic [18:0] m_r;
  int          m_cnt;

  function automatic logic [16:0] m_coef(input int k);
    if (k < 1 || k > 8) return 17'd0;
    return 17'($rtoi($floor(65536.0 / real'(k) + 0.5)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_x = '0; m_t = '0; m_r = '0; m_cnt = 0;
  endtask

  // Drive one controller cycle, model it, check after the rising edge.
  task automatic cyc(input string tag, input logic xl, input logic [15:0] xv,
                     input logic ti, input logic tl, input logic sl,
                     input logic ri, input logic rl, input logic as_v,
                     input logic ci, input logic ce);
    logic [16:0] op;
    logic [63:0] prod;
    logic [16:0] mult;
    exp_t        e;
    exp_t        got;
    x_ld = xl; x_in = xv; t_init = ti; t_ld = tl; sel = sl;
    r_init = ri; r_ld = rl; as_sel = as_v; cnt_iz = ci; cnt_en = ce;
    #1;
    chk({tag, ".yb_pre"}, 32'(y_bigger), 32'(m_cnt >= 8));
    op   = sl ? m_coef(m_cnt) : {1'b0, m_x};
    prod = 64'(m_t) * 64'(op);
`ifdef SERIES_ROUND_EN
    prod = prod + 64'd32768;
`endif
    mult = prod[32:16];
    if (ri)      m_r = '0;
    else if (rl) m_r = as_v ? (m_r + {2'b00, m_t}) : (m_r - {2'b00, m_t});
    if (ti)      m_t = 17'h10000;
    else if (tl) m_t = mult;
    if (xl)      m_x = xv;
    if (ci)      m_cnt = 1;
    else if (ce) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
    e.tag = tag; e.t = m_t; e.r = m_r; e.yb = (m_cnt >= 8);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".t"},  32'(t_out),    32'(got.t));
    chk({got.tag, ".r"},  32'(r_out),    32'(got.r));
    chk({got.tag, ".yb"}, 32'(y_bigger), 32'(got.yb));
    $display("cyc %-10s t=%h r=%h yb=%0d", got.tag, t_out, r_out, y_bigger);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic init(input logic [15:0] xv);
    cyc("init", 1, xv, 1, 0, 0, 1, 0, 0, 1, 0);
  endtask

  task automatic full_run(input logic [15:0] xv);
    init(xv);
    for (int k = 1; k <= 8; k++) begin
      cyc($sformatf("mult1_%0d", k), 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc($sformatf("mult2_%0d", k), 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0);
      cyc($sformatf("add_%0d", k),   0, 16'h0, 0, 0, 0, 0, 1, (k % 2) == 1, 0, 1);
    end
  endtask

  initial begin
    int d;
    x_in = '0; x_ld = 0; t_init = 0; t_ld = 0; sel = 0; r_init = 0; r_ld = 0;
    as_sel = 0; cnt_iz = 0; cnt_en = 0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.t",  32'(t_out),    32'h0);
    chk("reset.r",  32'(r_out),    32'h0);
    chk("reset.yb", 32'(y_bigger), 32'h0);
    rst = 1'b1;

    // init and first iteration with x = 0.5
    init(16'h8000);
    cyc("mult1", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("mult2", 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("add",   0, 16'h0, 0, 0, 0, 0, 1, 1, 0, 1);
    chk("iter1.t_abs", 32'(t_out), 32'h08000);
    chk("iter1.r_abs", 32'(r_out), 32'h08000);

    // build t=0x08000, r=0x04000, then reset asynchronously mid-cycle
    init(16'h8000);
    cyc("m1a", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("m1b", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("addr", 0, 16'h0, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc("tini", 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("m1c", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst.t", 32'(t_out), 32'h08000);
    chk("pre_rst.r", 32'(r_out), 32'h04000);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst.t",  32'(t_out),    32'h0);
    chk("async_rst.r",  32'(r_out),    32'h0);
    chk("async_rst.yb", 32'(y_bigger), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle("post_rst");
    // cnt must be 0: 1.0 * coef[0] gives 0
    cyc("t1", 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("cnt0_probe", 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0);

    // full run, x = 0.5
    full_run(16'h8000);
    d = int'(r_out) - 'h064BB;
    total++;
    assert (d >= -8 && d <= 8) else begin
      bad++;
      $error("FAIL full_run.tol: observed=%h expected=064BB+-8", r_out);
    end
    idle("hold1");
    idle("hold2");

    // full run, x = 0
    full_run(16'h0000);
    chk("x0.r_final", 32'(r_out), 32'h0);

    // priority: init beats load on t, r and cnt; x_ld independent
    init(16'h4000);
    cyc("m1", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("add", 0, 16'h0, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc("prio", 1, 16'hC000, 1, 1, 1, 1, 1, 1, 1, 1);
    chk("prio.t", 32'(t_out), 32'h10000);
    chk("prio.r", 32'(r_out), 32'h0);
    cyc("prio_cnt1", 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("prio_x", 0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0);

    // counter saturation: 20 increments from 1 must stop at 15 (coef 0)
    cyc("sat_iz", 0, 16'h0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_en", 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    cyc("sat_probe", 0, 16'h0, 0, 1, 1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
